// File: rtl/sample_proj_wb_regs.sv
// Wishbone B4 classic register bank in front of the sample project core.
// Holds the prescaler, enable and stop settings, and turns done rollovers into a sticky, maskable interrupt.
module sample_proj_wb_regs #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [13:0] PRESCALER_RST = 14'd1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        done_i,
  output logic [13:0] prescaler_o,
  output logic        enable_o,
  output logic        stop_o,
  output logic        irq_o
);

  localparam logic [1:0] OFF_PRESC  = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_IRQEN  = 2'd3;

  typedef struct packed {
    logic       go;
    logic       we;
    logic [1:0] off;
  } wb_req_t;

  wb_req_t     req;
  logic        wr_en;
  logic        w1c;
  logic        done_q;
  logic        done_rise;
  logic        done_sticky;
  logic        irq_en;
  logic [13:0] presc_nxt;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:14]};

  // The ack itself gates a new request, so a held strobe gets every other cycle.
  always_comb begin
    req.go  = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADDR[31:4]) & ~wb_ack_o;
    req.we  = wb_we_i;
    req.off = wb_adr_i[3:2];
  end

  assign wr_en     = req.go & req.we;
  assign w1c       = wr_en & (req.off == OFF_STATUS) & wb_sel_i[0] & wb_dat_i[0];
  assign done_rise = done_i & ~done_q;

  always_comb begin
    presc_nxt = prescaler_o;
    if (wb_sel_i[0]) presc_nxt[7:0]  = wb_dat_i[7:0];
    if (wb_sel_i[1]) presc_nxt[13:8] = wb_dat_i[13:8];
  end

  always_comb begin
    rdata = '0;
    case (req.off)
      OFF_PRESC:  rdata = {18'd0, prescaler_o};
      OFF_CTRL:   rdata = {30'd0, stop_o, enable_o};
      OFF_STATUS: rdata = {31'd0, done_sticky};
      OFF_IRQEN:  rdata = {31'd0, irq_en};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      prescaler_o <= PRESCALER_RST;
      enable_o    <= 1'b0;
      stop_o      <= 1'b0;
      irq_en      <= 1'b0;
      done_q      <= 1'b0;
      done_sticky <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      wb_ack_o    <= req.go;
      wb_dat_o    <= (req.go & ~req.we) ? rdata : '0;
      done_q      <= done_i;
      // A new rising edge beats a same-cycle clear so no rollover is lost.
      done_sticky <= done_rise | (done_sticky & ~w1c);
      irq_o       <= done_sticky & irq_en;
      if (wr_en) begin
        case (req.off)
          OFF_PRESC: prescaler_o <= (presc_nxt == 14'd0) ? 14'd1 : presc_nxt;
          OFF_CTRL: begin
            if (wb_sel_i[0]) begin
              enable_o <= wb_dat_i[0];
              stop_o   <= wb_dat_i[1];
            end
          end
          OFF_IRQEN: if (wb_sel_i[0]) irq_en <= wb_dat_i[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_proj_wb_regs.sv
// Self-checking bench for sample_proj_wb_regs: directed test-plan steps plus random bus/done traffic
// compared every cycle against a register-image reference model.
module tb_sample_proj_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk, nrst;
  logic        cyc, stb, we, done;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic [31:0] dat_o;
  logic        ack, irq, en, stp;
  logic [13:0] presc;

  int total = 0;
  int bad   = 0;

  sample_proj_wb_regs dut (
    .clk(clk), .nrst(nrst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .done_i(done), .prescaler_o(presc), .enable_o(en), .stop_o(stp), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: register images as software reads them, plus bus/irq pipeline state.
  typedef struct packed {
    logic [3:0][31:0] img;
    logic             dq;
    logic             ack;
    logic             irq;
    logic [31:0]      rd;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r        = '0;
    r.img[0] = 32'd1;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c);
    model_t      n;
    logic        hit;
    logic [1:0]  o;
    logic [31:0] mask, merged;
    n      = c;
    hit    = cyc && stb && (adr[31:4] == BASE[31:4]) && !c.ack;
    o      = adr[3:2];
    mask   = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    merged = (c.img[o] & ~mask) | (dat & mask);
    n.ack  = hit;
    n.rd   = (hit && !we) ? c.img[o] : 32'd0;
    n.irq  = c.img[2][0] & c.img[3][0];
    n.dq   = done;
    if (hit && we) begin
      case (o)
        2'd0: n.img[0] = (merged[13:0] == 14'd0) ? 32'd1 : {18'd0, merged[13:0]};
        2'd1: n.img[1] = merged & 32'h3;
        2'd2: if (sel[0] && dat[0]) n.img[2] = 32'd0;
        default: n.img[3] = merged & 32'h1;
      endcase
    end
    if (done && !c.dq) n.img[2] = 32'd1;
    return n;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) m <= model_reset();
    else       m <= model_step(m);
  end

  always @(negedge clk) begin
    chk("ack",       32'(ack),   32'(m.ack));
    chk("dat_o",     dat_o,      m.rd);
    chk("prescaler", 32'(presc), m.img[0] & 32'h3fff);
    chk("enable",    32'(en),    32'(m.img[1][0]));
    chk("stop",      32'(stp),   32'(m.img[1][1]));
    chk("irq",       32'(irq),   32'(m.irq));
  end

  // Called just after a negedge; returns just after a negedge with the bus idle and ack low.
  task automatic wb_io(input logic w, input logic [1:0] off, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] q);
    int lat;
    lat = 0;
    q   = '0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat = d;
    adr = BASE | {28'd0, off, 2'b00} | 32'($urandom_range(0, 3));
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (ack) break;
    end
    if (!ack) chk("ack_timeout", 32'd0, 32'd1);
    else      chk("ack_latency", 32'(lat), 32'd1);
    q   = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_miss();
    logic [31:0] hi;
    logic        seen;
    seen = 1'b0;
    hi   = BASE ^ (32'h10 << $urandom_range(0, 27));
    cyc = 1'b1; stb = 1'b1; we = 1'($urandom_range(0, 1)); sel = 4'hf;
    adr = {hi[31:4], 4'($urandom_range(0, 15))}; dat = $urandom;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ack;
    end
    chk("oow_no_ack", 32'(seen), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  logic [31:0] q;
  logic [3:0]  pat;

  initial begin
    nrst = 1'b0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; done = 0;
    repeat (3) @(negedge clk);
    chk("rst_prescaler", 32'(presc), 32'd1);
    chk("rst_ack",       32'(ack),   32'd0);
    chk("rst_irq",       32'(irq),   32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // 1: reset readback
    wb_io(0, 2'd0, 4'hf, 0, q); chk("rd_presc_rst",  q, 32'h1);
    wb_io(0, 2'd1, 4'hf, 0, q); chk("rd_ctrl_rst",   q, 32'h0);
    wb_io(0, 2'd2, 4'hf, 0, q); chk("rd_status_rst", q, 32'h0);
    wb_io(0, 2'd3, 4'hf, 0, q); chk("rd_irqen_rst",  q, 32'h0);

    // 2: byte-lane writes
    wb_io(1, 2'd0, 4'b0011, 32'h0000_2abc, q);
    chk("presc_o_2abc", 32'(presc), 32'h2abc);
    wb_io(0, 2'd0, 4'hf, 0, q); chk("rd_presc_2abc", q, 32'h2abc);
    wb_io(1, 2'd0, 4'b0001, 32'h0000_00ff, q);
    wb_io(0, 2'd0, 4'hf, 0, q); chk("rd_presc_2aff", q, 32'h2aff);

    // 3: zero clamp
    wb_io(1, 2'd0, 4'hf, 32'h0, q);
    wb_io(0, 2'd0, 4'hf, 0, q); chk("rd_presc_clamp", q, 32'h1);
    chk("presc_o_clamp", 32'(presc), 32'h1);

    // 4: single pulse -> sticky + irq, then W1C
    wb_io(1, 2'd3, 4'h1, 32'h1, q);
    done = 1'b1; @(negedge clk);
    done = 1'b0; @(negedge clk);
    chk("irq_two_edges", 32'(irq), 32'd1);
    wb_io(0, 2'd2, 4'hf, 0, q); chk("rd_status_set", q, 32'h1);
    wb_io(1, 2'd2, 4'h1, 32'h1, q);
    wb_io(0, 2'd2, 4'hf, 0, q); chk("rd_status_w1c", q, 32'h0);
    chk("irq_cleared", 32'(irq), 32'd0);

    // 5: held level sets once; W1C during the level clears for good
    done = 1'b1; @(negedge clk); @(negedge clk);
    wb_io(1, 2'd2, 4'h1, 32'h1, q);
    @(negedge clk);
    done = 1'b0;
    wb_io(0, 2'd2, 4'hf, 0, q); chk("rd_status_level", q, 32'h0);
    done = 1'b1; @(negedge clk);
    done = 1'b0; @(negedge clk);
    done = 1'b1;
    wb_io(1, 2'd2, 4'h1, 32'h1, q);
    wb_io(0, 2'd2, 4'hf, 0, q); chk("rd_status_setwins", q, 32'h1);
    done = 1'b0;
    wb_io(1, 2'd2, 4'h1, 32'h1, q);

    // 6: held strobe acks every other cycle
    cyc = 1; stb = 1; we = 1; sel = 4'hf; adr = BASE | 32'h4; dat = 32'h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = ack;
    end
    chk("held_stb_acks", 32'(pat), 32'b0101);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("enable_set", 32'(en),  32'd1);
    chk("stop_set",   32'(stp), 32'd1);

    // async reset with ack high
    cyc = 1; stb = 1; we = 1; sel = 4'hf; adr = BASE; dat = 32'h123;
    @(posedge clk); #5;
    nrst = 1'b0; #1;
    chk("arst_ack",   32'(ack),   32'd0);
    chk("arst_presc", 32'(presc), 32'd1);
    chk("arst_en",    32'(en),    32'd0);
    chk("arst_stop",  32'(stp),   32'd0);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      done = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       wb_miss();
        1:       @(negedge clk);
        default: wb_io(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), $urandom, q);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_proj_wb_regs.md
Name: sample_proj_wb_regs

Overview:
Wishbone B4 classic slave register bank that sits directly upstream of the sample team project core.
- Drives the core's prescaler, enable and stop inputs from software-writable registers.
- Captures the core's done rollover into a sticky, maskable interrupt for the management core.
- Lets firmware run the GPIO cycling sequence without the logic analyzer.

Parameters:
BASE_ADDR, 32'h3000_0000, word-aligned base address of the 16-byte register window.
PRESCALER_RST, 14'd1, reset value of the prescaler register; must be nonzero.

Ports:
clk  input  1  system clock (10 MHz)
nrst  input  1  asynchronous active-low reset
wb_cyc_i  input  1  bus cycle valid
wb_stb_i  input  1  strobe
wb_we_i  input  1  1 = write, 0 = read
wb_sel_i  input  4  byte lane selects
wb_adr_i  input  32  byte address
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data, registered
wb_ack_o  output  1  single-cycle acknowledge
done_i  input  1  rollover flag from core
prescaler_o  output  14  to core prescaler
enable_o  output  1  to core enable
stop_o  output  1  to core stop
irq_o  output  1  interrupt to management core

Behaviour:
- Reset (nrst low, asynchronous): wb_ack_o=0, wb_dat_o=0, prescaler_o=PRESCALER_RST, enable_o=0, stop_o=0, STATUS=0, IRQ_EN=0, irq_o=0, done edge register=0.
- Address decode: request is selected when wb_cyc_i & wb_stb_i & (wb_adr_i[31:4]==BASE_ADDR[31:4]); offset = wb_adr_i[3:2]; wb_adr_i[1:0] ignored.
- Register map:
  - 0x0 PRESCALER: bits[13:0], RW.
  - 0x4 CTRL: bit0 enable, bit1 stop, RW.
  - 0x8 STATUS: bit0 done_sticky, read / write-1-to-clear.
  - 0xC IRQ_EN: bit0, RW.
  - All other bits read 0.
- Handshake:
  - Selected request with wb_ack_o=0 -> wb_ack_o=1 on the next edge, for exactly one cycle.
  - wb_ack_o then returns to 0 for at least one cycle, even if stb stays high. Back-to-back transfers therefore take 2 cycles each.
  - Unselected requests are never acked.
- Writes: commit on the same edge that raises wb_ack_o. Only byte lanes with wb_sel_i set update, e.g. PRESCALER[7:0] by sel[0] and [13:8] by sel[1].
- Reads: wb_dat_o loads on the same edge as the ack. It holds the register value sampled in the request cycle and is 0 at other times.
- Prescaler zero clamp: a committed PRESCALER value of 0 is stored as 1, so the core never sees a zero rollover value.
- stop/enable: level registers passed straight to the core; software clears them. Both bits may be 1 together; the core gives stop priority, and this block does not arbitrate.
- Done capture:
  - done_q registers done_i each cycle.
  - Rising edge (done_i & ~done_q) sets done_sticky on the next edge.
  - A level held high for many cycles sets the bit only once.
- Simultaneous set and W1C on the same edge: set wins, so done_sticky stays 1.
- irq_o = done_sticky & IRQ_EN[0], registered: it updates on the edge after either input changes.
- Unmapped offset inside window: none (all four offsets map).
- Out-of-window: no ack; master timeout is the system's concern.
- Reset mid-transaction: ack drops immediately. The in-flight write is lost and the master must retry.

Test Plan:
1. Reset, then read all four offsets -> 0x1, 0x0, 0x0, 0x0; each ack exactly 1 cycle, one cycle after stb.
2. Write PRESCALER=0x00002ABC with sel=4'b0011, then with sel=4'b0001 data 0xFF -> reads 0x2ABC then 0x2AFF; prescaler_o matches on the ack edge.
3. Write PRESCALER=0 -> readback 0x1, prescaler_o=1.
4. IRQ_EN=1, pulse done_i for 1 cycle -> STATUS reads 1, irq_o=1 two edges after the pulse; W1C 0x1 -> STATUS 0, irq_o 0.
5. Hold done_i high 5 cycles, W1C during cycle 3 -> STATUS=0 afterwards (no re-set without a new edge). Then a W1C on the same edge as a new rising edge -> STATUS stays 1.
6. Write CTRL=0x3 with stb held high 4 cycles -> acks on cycles 2 and 4 only; enable_o=stop_o=1. Assert nrst low during a write -> outputs return to reset values asynchronously.
